mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  Pipeline stage directly downstream of the data-memory stage. Captures the ALU result and raw
//  64-bit memory word, applies load formatting (byte/half/word/double, signed/unsigned).
//  Selects the write-back value and presents it to the register file over a valid/ready handshake.
//  Also detects misaligned or illegal loads and counts retired instructions.
// PARAMETERS
//  XLEN      64  datapath width; only 64 is supported
//  CNT_W     32  width of retire_count
// PORTS
//  clk              in   1      rising-edge clock
//  reset            in   1      asynchronous, active-high reset
//  in_valid         in   1      upstream entry valid
//  in_ready         out  1      stage can accept an entry this cycle
//  alu_result       in   64     ALU result / load effective address
//  mem_data         in   64     raw doubleword read from data memory
//  rd               in   5      destination register
//  regwrite         in   1      instruction writes rd
//  memtoreg         in   1      1 = write-back source is the formatted load, 0 = alu_result
//  funct3           in   3      load size/sign: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU
//  flush            in   1      squash the held entry and any entry captured this cycle
//  out_valid        out  1      write-back entry valid
//  out_ready        in   1      register file accepts the entry
//  wb_rd            out  5      destination register
//  wb_regwrite      out  1      write enable, already qualified (x0, faults)
//  wb_data          out  64     write-back value
//  load_fault       out  1      entry was a misaligned or illegal load
//  retire_count     out  CNT_W  output handshakes since reset
// BEHAVIOUR
//  - Reset (async, active-high): out_valid=0, wb_rd=0, wb_regwrite=0, wb_data=0, load_fault=0, retire_count=0.
//    Asserting reset mid-operation discards the held entry; the first capture is possible on the first edge after release.
//  - in_ready = !out_valid || out_ready. This is combinational; no in_valid -> in_ready path.
//  - Capture: on a clk edge with in_valid && in_ready && !flush, all outputs load from the formatted entry and out_valid=1.
//    Latency is one cycle.
//  - Drain: an edge with out_valid && out_ready and no capture sets out_valid=0.
//    Capture and drain in the same cycle give back-to-back throughput of 1 entry per cycle.
//  - Stall: while out_valid && !out_ready, every output holds bit-stable and in_ready=0.
//  - Flush: takes priority over capture. The next edge sets out_valid=0 and drops any same-cycle input.
//    wb_* may retain stale values but are don't-care while out_valid=0.
//  - Load formatting applies only when memtoreg=1.
//    off = alu_result[2:0]; little-endian lane selection: byte = mem_data[8*off +: 8],
//    half = mem_data[16*off[2:1] +: 16], word = mem_data[32*off[2] +: 32], LD = mem_data.
//    Signed forms sign-extend to 64 bits; U forms zero-extend.
//  - Faults (memtoreg=1 only):
//    * misaligned when LH/LHU off[0]!=0, LW/LWU off[1:0]!=0, or LD off!=0;
//    * illegal when funct3=111;
//    * on a fault: load_fault=1, wb_regwrite=0, wb_data=0; the entry still flows and retires normally.
//  - When memtoreg=0: wb_data=alu_result, funct3 is ignored, load_fault=0.
//  - wb_regwrite = regwrite && (rd!=0) && !fault. Writes to x0 are always suppressed.
//  - retire_count increments by 1 on every edge with out_valid && out_ready, including when flush is high that cycle.
//    It wraps from 2^CNT_W-1 to 0.
// TESTING
//  1. ALU pass-through: memtoreg=0, alu_result=64'h1234, rd=5, regwrite=1, out_ready=1
//     -> next cycle out_valid=1, wb_data=64'h1234, wb_rd=5, wb_regwrite=1, retire_count 0->1.
//  2. LB/LBU lane: mem_data=64'h80FF_0000_0000_7F00, alu_result=0x...06, funct3=000
//     -> wb_data=64'hFFFF_FFFF_FFFF_FFFF. With alu_result=0x...01 and funct3=100 -> wb_data=64'h7F.
//  3. Misaligned LW (alu_result=0x...02, funct3=010, regwrite=1)
//     -> load_fault=1, wb_regwrite=0, wb_data=0. Repeat with funct3=111 -> same response.
//  4. Backpressure: capture an entry, hold out_ready=0 for 3 cycles while in_valid=1
//     -> in_ready=0 and outputs bit-stable; out_ready=1 -> drain plus new capture on the same edge.
//  5. Flush/x0: flush together with in_valid -> out_valid=0 next cycle.
//     rd=0 with regwrite=1 -> wb_regwrite=0, retire_count still increments.
//  6. Reset mid-stall: out_valid=1, out_ready=0, pulse reset asynchronously between edges
//     -> all outputs 0 immediately. Force retire_count=32'hFFFF_FFFF, one retire -> 0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: one-entry register between the data-memory stage and the
// register file. Formats the load (byte/half/word/double, signed/unsigned),
// picks the write-back value, flags misaligned/illegal loads and counts
// retired entries. The output side uses a valid/ready handshake.
//
// Ports
//   clk, reset            rising-edge clock, async active-high reset
//   in_valid / in_ready   upstream handshake (in_ready = !out_valid || out_ready)
//   alu_result, mem_data  ALU result / effective address, raw memory doubleword
//   rd, regwrite          destination register and its write request
//   memtoreg, funct3      write-back source select and load size/sign
//   flush                 squash held entry and any same-cycle capture
//   out_valid / out_ready write-back handshake
//   wb_rd, wb_regwrite, wb_data, load_fault   registered write-back entry
//   retire_count          output handshakes since reset (wraps)
module mem_wb_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  mem_data,
  input  logic [4:0]       rd,
  input  logic             regwrite,
  input  logic             memtoreg,
  input  logic [2:0]       funct3,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       wb_rd,
  output logic             wb_regwrite,
  output logic [XLEN-1:0]  wb_data,
  output logic             load_fault,
  output logic [CNT_W-1:0] retire_count
);

  logic             r_valid;
  logic [4:0]       r_rd;
  logic             r_regwrite;
  logic [XLEN-1:0]  r_data;
  logic             r_fault;
  logic [CNT_W-1:0] r_retire;

  logic [2:0]       w_off;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_word;
  logic [XLEN-1:0]  w_load;
  logic             w_misalign;
  logic             w_illegal;
  logic             w_fault;
  logic [XLEN-1:0]  w_data;
  logic             w_regwrite;
  logic             w_capture;
  logic             w_drain;

  // Little-endian lane selection from the low address bits.
  assign w_off  = alu_result[2:0];
  assign w_byte = mem_data[{w_off, 3'b000} +: 8];
  assign w_half = mem_data[{w_off[2:1], 4'b0000} +: 16];
  assign w_word = mem_data[{w_off[2], 5'b00000} +: 32];

  always_comb begin
    w_load     = '0;
    w_misalign = 1'b0;
    w_illegal  = 1'b0;
    case (funct3)
      3'b000: w_load = {{56{w_byte[7]}}, w_byte};
      3'b001: begin
        w_load     = {{48{w_half[15]}}, w_half};
        w_misalign = w_off[0];
      end
      3'b010: begin
        w_load     = {{32{w_word[31]}}, w_word};
        w_misalign = (w_off[1:0] != 2'b00);
      end
      3'b011: begin
        w_load     = mem_data;
        w_misalign = (w_off != 3'b000);
      end
      3'b100: w_load = {56'd0, w_byte};
      3'b101: begin
        w_load     = {48'd0, w_half};
        w_misalign = w_off[0];
      end
      3'b110: begin
        w_load     = {32'd0, w_word};
        w_misalign = (w_off[1:0] != 2'b00);
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // funct3 only matters for loads; ALU results never fault.
  assign w_fault    = memtoreg && (w_misalign || w_illegal);
  assign w_data     = !memtoreg ? alu_result : (w_fault ? '0 : w_load);
  assign w_regwrite = regwrite && (rd != 5'd0) && !w_fault;

  assign in_ready  = !r_valid || out_ready;
  assign w_capture = in_valid && in_ready && !flush;
  assign w_drain   = r_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_data     <= '0;
      r_fault    <= 1'b0;
    end else if (flush) begin
      // Flush beats capture; the wb_* payload is left stale (don't-care).
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid    <= 1'b1;
      r_rd       <= rd;
      r_regwrite <= w_regwrite;
      r_data     <= w_data;
      r_fault    <= w_fault;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  // A handshake completed under flush still counts as retired.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_retire <= '0;
    else if (w_drain) r_retire <= r_retire + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign out_valid    = r_valid;
  assign wb_rd        = r_rd;
  assign wb_regwrite  = r_regwrite;
  assign wb_data      = r_data;
  assign load_fault   = r_fault;
  assign retire_count = r_retire;

endmodule
